// File: rtl/wfg_drive_spi_pkg.sv
// Shared types for the SPI drive stage: FSM states, frame-width encoding and its bit-count decode.
package wfg_drive_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DW_8  = 2'd0,
        DW_16 = 2'd1,
        DW_24 = 2'd2,
        DW_32 = 2'd3
    } dwidth_e;

    function automatic logic [5:0] dwidth_to_bits(input dwidth_e dw);
        logic [5:0] bits;
        case (dw)
            DW_8:    bits = 6'd8;
            DW_16:   bits = 6'd16;
            DW_24:   bits = 6'd24;
            default: bits = 6'd32;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/wfg_drive_spi_shift.sv
// Frame shift register and bit counter; sout_d_o is the serial bit the register presents after this edge.
// MSB-first frames are left-aligned at load so the outgoing bit is always at the top of the register.
module wfg_drive_spi_shift
    import wfg_drive_spi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              lsbfirst_i,
    input  logic [5:0]        nbits_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              sout_d_o,
    output logic              cnt_zero_o
);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              lsb_q, lsb_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        lsb_d = lsb_q;
        if (load_i) begin
            lsb_d = lsbfirst_i;
            sr_d  = lsbfirst_i ? data_i : (data_i << (DATA_W - int'(nbits_i)));
            cnt_d = nbits_i - 6'd1;
        end else if (shift_i) begin
            sr_d  = lsb_q ? (sr_q >> 1) : (sr_q << 1);
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            lsb_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            lsb_q <= lsb_d;
        end
    end

    assign sout_d_o   = lsb_d ? sr_d[0] : sr_d[DATA_W-1];
    assign cnt_zero_o = (cnt_q == 6'd0);

endmodule

// File: rtl/wfg_drive_spi.sv
// SPI (CPHA=0) drive stage: one stream sample per core sync, one SCK edge per core subcycle pulse.
// Optional underrun flag/counter built only with WFG_DRIVE_SPI_UNDERRUN_EN defined.
module wfg_drive_spi
    import wfg_drive_spi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wfg_core_sync_i,
    input  logic              wfg_core_subcycle_i,
    input  logic              en_i,
    input  logic              cfg_cpol_i,
    input  logic              cfg_cspol_i,
    input  logic              cfg_lsbfirst_i,
    input  logic [1:0]        cfg_dwidth_i,
    input  logic [DATA_W-1:0] wfg_axis_tdata_i,
    input  logic              wfg_axis_tvalid_i,
    output logic              wfg_axis_tready_o,
    output logic              spi_sclk_o,
    output logic              spi_cs_o,
    output logic              spi_sdo_o,
    output logic              active_o,
    output logic              underrun_o,
    output logic [7:0]        underrun_cnt_o
);

    state_e state_q, state_d;
    logic   sclk_q, sclk_d;
    logic   cs_q, cs_d;
    logic   sdo_q, sdo_d;
    logic   cpol_q, cpol_d;
    logic   cspol_q, cspol_d;
    logic   load, shift, accept;
    logic   sh_sout_d, sh_cnt_zero;

    assign wfg_axis_tready_o = (state_q == ST_IDLE) & en_i & wfg_core_sync_i;
    assign accept            = wfg_axis_tready_o & wfg_axis_tvalid_i;

    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        cpol_d  = cpol_q;
        cspol_d = cspol_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = cfg_cpol_i;
                cs_d   = !cfg_cspol_i;
                if (accept) begin
                    load    = 1'b1;
                    cpol_d  = cfg_cpol_i;
                    cspol_d = cfg_cspol_i;
                    cs_d    = cfg_cspol_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (wfg_core_subcycle_i) begin
                    sclk_d  = !cpol_q;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (wfg_core_subcycle_i) begin
                    sclk_d = !sclk_q;
                    // SCK returning to idle level is the trailing edge: advance data or finish
                    if (sclk_q != cpol_q) begin
                        if (sh_cnt_zero) state_d = ST_HOLD;
                        else             shift   = 1'b1;
                    end
                end
            end
            default: begin
                if (wfg_core_subcycle_i) begin
                    cs_d    = !cspol_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (!en_i) begin
            state_d = ST_IDLE;
            sclk_d  = cfg_cpol_i;
            cs_d    = !cfg_cspol_i;
            load    = 1'b0;
            shift   = 1'b0;
        end
        sdo_d = (state_d != ST_IDLE) ? sh_sout_d : 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            sclk_q  <= cfg_cpol_i;
            cs_q    <= !cfg_cspol_i;
            sdo_q   <= 1'b0;
            cpol_q  <= 1'b0;
            cspol_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            sdo_q   <= sdo_d;
            cpol_q  <= cpol_d;
            cspol_q <= cspol_d;
        end
    end

    wfg_drive_spi_shift #(.DATA_W(DATA_W)) u_shift (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .load_i     (load),
        .shift_i    (shift),
        .lsbfirst_i (cfg_lsbfirst_i),
        .nbits_i    (dwidth_to_bits(dwidth_e'(cfg_dwidth_i))),
        .data_i     (wfg_axis_tdata_i),
        .sout_d_o   (sh_sout_d),
        .cnt_zero_o (sh_cnt_zero)
    );

    assign spi_sclk_o = sclk_q;
    assign spi_cs_o   = cs_q;
    assign spi_sdo_o  = sdo_q;
    assign active_o   = (state_q != ST_IDLE);

`ifdef WFG_DRIVE_SPI_UNDERRUN_EN
    logic       underrun_q, underrun_d;
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        underrun_d = (state_q == ST_IDLE) & en_i & wfg_core_sync_i & !wfg_axis_tvalid_i;
        ucnt_d     = ucnt_q;
        if (underrun_d && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            underrun_q <= 1'b0;
            ucnt_q     <= 8'd0;
        end else begin
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_o     = 1'b0;
    assign underrun_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_wfg_drive_spi.sv
// Directed bench for wfg_drive_spi: frame shapes, mid-frame sync, underrun, abort and reset.
module tb_wfg_drive_spi;
    import wfg_drive_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync, sub, en, cpol, cspol, lsb;
    logic [1:0]  dw;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready, sclk, cs, sdo, active, underrun;
    logic [7:0]  ucnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wfg_drive_spi #(.DATA_W(32)) dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
        .wfg_core_sync_i     (sync),
        .wfg_core_subcycle_i (sub),
        .en_i                (en),
        .cfg_cpol_i          (cpol),
        .cfg_cspol_i         (cspol),
        .cfg_lsbfirst_i      (lsb),
        .cfg_dwidth_i        (dw),
        .wfg_axis_tdata_i    (tdata),
        .wfg_axis_tvalid_i   (tvalid),
        .wfg_axis_tready_o   (tready),
        .spi_sclk_o          (sclk),
        .spi_cs_o            (cs),
        .spi_sdo_o           (sdo),
        .active_o            (active),
        .underrun_o          (underrun),
        .underrun_cnt_o      (ucnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sub(input int count);
        for (int i = 0; i < count; i++) begin
            sub = 1'b1;
            tick();
            sub = 1'b0;
            tick();
        end
    endtask

    // Accept one sample, drive 2N+2 subcycle pulses, record SDO at every leading SCK edge.
    task automatic run_frame(input logic c_pol, input logic c_cspol, input logic c_lsb,
                             input logic [1:0] c_dw, input logic [31:0] dat,
                             input logic [31:0] exp_seq, input int mid_sync, input string tag);
        int          n, lead, trail;
        logic [31:0] seq;
        logic        prev, cs_ok, act_ok, rdy_ok;
        n = 8 * (int'(c_dw) + 1);
        cpol = c_pol; cspol = c_cspol; lsb = c_lsb; dw = c_dw;
        tdata = dat; tvalid = 1'b1; sync = 1'b1;
        #1;
        chk({tag, "_rdy_sync"}, 32'(tready), 32'd1);
        tick();
        sync = 1'b0;
        #1;
        chk({tag, "_rdy_after"}, 32'(tready), 32'd0);
        chk({tag, "_cs_start"}, 32'(cs), 32'(c_cspol));
        chk({tag, "_sclk_idle"}, 32'(sclk), 32'(c_pol));
        seq = 32'd0; lead = 0; trail = 0; prev = c_pol;
        cs_ok = 1'b1; act_ok = 1'b1; rdy_ok = 1'b1;
        for (int p = 1; p <= 2 * n + 2; p++) begin
            sub = 1'b1;
            if (p == mid_sync) sync = 1'b1;
            #1;
            if (p == mid_sync && tready) rdy_ok = 1'b0;
            tick();
            sub = 1'b0; sync = 1'b0;
            if (sclk != prev) begin
                if (sclk != c_pol) begin
                    lead++;
                    seq = {seq[30:0], sdo};
                end else begin
                    trail++;
                end
            end
            prev = sclk;
            if (p <= 2 * n) begin
                if (cs != c_cspol) cs_ok = 1'b0;
                if (!active) act_ok = 1'b0;
            end
            tick();
        end
        tvalid = 1'b0;
        chk({tag, "_lead_edges"}, 32'(lead), 32'(n));
        chk({tag, "_trail_edges"}, 32'(trail), 32'(n));
        chk({tag, "_bits"}, seq, exp_seq);
        chk({tag, "_cs_held"}, 32'(cs_ok), 32'd1);
        chk({tag, "_active_held"}, 32'(act_ok), 32'd1);
        if (mid_sync > 0) chk({tag, "_mid_sync_rdy"}, 32'(rdy_ok), 32'd1);
        chk({tag, "_cs_end"}, 32'(cs), 32'(!c_cspol));
        chk({tag, "_active_end"}, 32'(active), 32'd0);
        chk({tag, "_sclk_end"}, 32'(sclk), 32'(c_pol));
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; sub = 1'b0; en = 1'b0;
        cpol = 1'b0; cspol = 1'b0; lsb = 1'b0; dw = 2'd0;
        tdata = 32'd0; tvalid = 1'b0;
        tick(); tick();
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ucnt", 32'(ucnt), 32'd0);
        rst = 1'b0; en = 1'b1;
        tick();

        run_frame(1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_00A5, 32'h0000_00A5, 0, "f8_msb");
        run_frame(1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_0003, 32'h0000_C000, 0, "f16_lsb");
        run_frame(1'b0, 1'b1, 1'b0, 2'd3, 32'h8000_0001, 32'h8000_0001, 20, "f32_msb");

        // Sync in IDLE with no sample available
        tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sync = 1'b1;
            tick();
            sync = 1'b0;
`ifdef WFG_DRIVE_SPI_UNDERRUN_EN
            chk("underrun_pulse", 32'(underrun), 32'd1);
`else
            chk("underrun_off", 32'(underrun), 32'd0);
`endif
            tick();
            chk("underrun_clear", 32'(underrun), 32'd0);
        end
`ifdef WFG_DRIVE_SPI_UNDERRUN_EN
        chk("ucnt_3", 32'(ucnt), 32'd3);
`else
        chk("ucnt_off", 32'(ucnt), 32'd0);
`endif
        for (int k = 0; k < 300; k++) begin
            sync = 1'b1;
            tick();
            sync = 1'b0;
            tick();
        end
`ifdef WFG_DRIVE_SPI_UNDERRUN_EN
        chk("ucnt_sat", 32'(ucnt), 32'd255);
`else
        chk("ucnt_sat_off", 32'(ucnt), 32'd0);
`endif

        // Abort a 24-bit frame after five subcycle pulses
        cpol = 1'b1; cspol = 1'b1; lsb = 1'b0; dw = 2'd2;
        tdata = 32'h00FF_FFFF; tvalid = 1'b1; sync = 1'b1;
        tick();
        sync = 1'b0; tvalid = 1'b0;
        pulse_sub(5);
        chk("abort_pre_sdo", 32'(sdo), 32'd1);
        en = 1'b0;
        tick();
        chk("abort_cs", 32'(cs), 32'd0);
        chk("abort_sclk", 32'(sclk), 32'd1);
        chk("abort_active", 32'(active), 32'd0);
        chk("abort_sdo", 32'(sdo), 32'd0);
        en = 1'b1;
        tick();
        tvalid = 1'b1; sync = 1'b1;
        #1;
        chk("reen_rdy", 32'(tready), 32'd1);
        tick();
        sync = 1'b0; tvalid = 1'b0;
        chk("reen_active", 32'(active), 32'd1);

        // Reset mid-frame while shifting
        pulse_sub(3);
        chk("pre_rst_active", 32'(active), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_sclk", 32'(sclk), 32'd1);
        chk("mrst_cs", 32'(cs), 32'd0);
        chk("mrst_sdo", 32'(sdo), 32'd0);
        chk("mrst_active", 32'(active), 32'd0);
        chk("mrst_underrun", 32'(underrun), 32'd0);
        chk("mrst_ucnt", 32'(ucnt), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
